axi_llc_burst_splitter: RTL and testbench

Sequential successor to the LLC's combinational burst cutter. It accepts one AXI AR/AW burst over a valid/ready handshake and emits one registered descriptor per cache line touched, one per cycle under back-pressure. New over the cutter: WRAP bursts are split correctly across lines, the line size is parametrised, and the output is a real stream. It sits between the LLC Ax input spill register and the tag-lookup stage.

---
 rtl/axi_llc_burst_splitter.sv | 158 +++++++++++++++
 tb/tb_axi_llc_burst_splitter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_burst_splitter.sv
// Splits one AXI AR/AW burst into registered per-cache-line descriptors,
// one per cycle, including WRAP bursts whose container spans several lines.
module axi_llc_burst_splitter #(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 6,
    parameter int LineBytes = 64,
    parameter int MaxSize   = 3,
    parameter int Write     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [IdWidth-1:0]   desc_id_o,
    output logic [AddrWidth-1:0] desc_addr_o,
    output logic [7:0]           desc_len_o,
    output logic [2:0]           desc_size_o,
    output logic [1:0]           desc_burst_o,
    output logic                 desc_first_o,
    output logic                 desc_last_o,
    output logic                 desc_rw_o
);

    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineBytes - 1);
    localparam logic [AddrWidth-1:0] LineSize = AddrWidth'(LineBytes);
    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;

    typedef enum logic {Idle, Emit} state_e;
    state_e state;

    logic [AddrWidth-1:0] nxt_addr_p0, wrap_base_p0, wrap_top_p0;
    logic [8:0]           rem_p0;
    logic                 wrap_multi_p0;

    logic                 ax_wrap_len_ok, ax_illegal, ax_fixed, ax_wrap, ax_single, ax_wrap_multi;
    logic [8:0]           ax_total, ax_first_beats, nxt_beats;
    logic [AddrWidth-1:0] ax_cont, ax_base, ax_top;

    function automatic logic [8:0] line_beats(input logic [AddrWidth-1:0] addr,
                                              input logic [2:0] size,
                                              input logic [8:0] rem);
        logic [AddrWidth-1:0] bol, beats;
        bol   = LineSize - (addr & LineMask);
        beats = ((bol - AddrWidth'(1)) >> size) + AddrWidth'(1);
        if (beats < AddrWidth'(rem)) return beats[8:0];
        return rem;
    endfunction

    function automatic logic [AddrWidth-1:0] next_line(input logic [AddrWidth-1:0] addr,
                                                       input logic wrap_m,
                                                       input logic [AddrWidth-1:0] base,
                                                       input logic [AddrWidth-1:0] top);
        logic [AddrWidth-1:0] n;
        n = (addr & ~LineMask) + LineSize;
        if (wrap_m && n == top) n = base;
        return n;
    endfunction

    always_comb begin
        ax_wrap_len_ok = (ax_len_i == 8'd1) || (ax_len_i == 8'd3) ||
                         (ax_len_i == 8'd7) || (ax_len_i == 8'd15);
        ax_illegal     = (ax_size_i > 3'(MaxSize)) ||
                         (ax_burst_i == BurstWrap && !ax_wrap_len_ok);
        ax_fixed       = !ax_illegal && ax_burst_i == BurstFixed;
        ax_wrap        = !ax_illegal && ax_burst_i == BurstWrap;
        ax_total       = {1'b0, ax_len_i} + 9'd1;
        ax_cont        = AddrWidth'(ax_total) << ax_size_i;
        ax_base        = ax_addr_i & ~(ax_cont - AddrWidth'(1));
        ax_top         = ax_base + ax_cont;
        ax_single      = ax_fixed || (ax_wrap && ax_cont <= LineSize);
        ax_wrap_multi  = ax_wrap && !ax_single;
        ax_first_beats = line_beats(ax_addr_i, ax_size_i, ax_total);
        nxt_beats      = line_beats(nxt_addr_p0, desc_size_o, rem_p0);
    end

    // Control and registered descriptor outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= Idle;
            ax_ready_o   <= 1'b1;
            desc_valid_o <= 1'b0;
            desc_id_o    <= '0;
            desc_addr_o  <= '0;
            desc_len_o   <= '0;
            desc_size_o  <= '0;
            desc_burst_o <= '0;
            desc_first_o <= 1'b0;
            desc_last_o  <= 1'b0;
            desc_rw_o    <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (ax_valid_i) begin
                        state        <= Emit;
                        ax_ready_o   <= 1'b0;
                        desc_valid_o <= 1'b1;
                        desc_id_o    <= ax_id_i;
                        desc_size_o  <= ax_size_i;
                        desc_rw_o    <= 1'(Write);
                        desc_first_o <= 1'b1;
                        desc_addr_o  <= ax_addr_i;
                        if (ax_single) begin
                            desc_len_o   <= ax_len_i;
                            desc_burst_o <= ax_burst_i;
                            desc_last_o  <= 1'b1;
                        end else begin
                            desc_len_o   <= ax_first_beats[7:0] - 8'd1;
                            desc_burst_o <= BurstIncr;
                            desc_last_o  <= (ax_first_beats == ax_total);
                        end
                    end
                end
                Emit: begin
                    if (desc_ready_i) begin
                        if (desc_last_o) begin
                            state        <= Idle;
                            ax_ready_o   <= 1'b1;
                            desc_valid_o <= 1'b0;
                        end else begin
                            desc_first_o <= 1'b0;
                            desc_addr_o  <= nxt_addr_p0;
                            desc_len_o   <= nxt_beats[7:0] - 8'd1;
                            desc_last_o  <= (nxt_beats == rem_p0);
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    // Walk state: address of the next line and beats still owed
    always_ff @(posedge clk_i) begin
        if (state == Idle && ax_valid_i) begin
            nxt_addr_p0   <= next_line(ax_addr_i, ax_wrap_multi, ax_base, ax_top);
            rem_p0        <= ax_total - ax_first_beats;
            wrap_multi_p0 <= ax_wrap_multi;
            wrap_base_p0  <= ax_base;
            wrap_top_p0   <= ax_top;
        end else if (state == Emit && desc_ready_i && !desc_last_o) begin
            nxt_addr_p0 <= next_line(nxt_addr_p0, wrap_multi_p0, wrap_base_p0, wrap_top_p0);
            rem_p0      <= rem_p0 - nxt_beats;
        end
    end

    ax_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                 (ax_valid_i && ax_ready_o) |-> !ax_illegal);

endmodule

// File: tb/tb_axi_llc_burst_splitter.sv
// Scoreboard bench for axi_llc_burst_splitter: a beat-level reference model
// fills an expectation queue that a free-running monitor drains.
module tb_axi_llc_burst_splitter;

    localparam int LB     = 64;
    localparam int LOG_LB = 6;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ax_valid_i = 1'b0;
    logic        ax_ready_o;
    logic [5:0]  ax_id_i = '0;
    logic [63:0] ax_addr_i = '0;
    logic [7:0]  ax_len_i = '0;
    logic [2:0]  ax_size_i = '0;
    logic [1:0]  ax_burst_i = '0;
    logic        desc_valid_o;
    logic        desc_ready_i = 1'b0;
    logic [5:0]  desc_id_o;
    logic [63:0] desc_addr_o;
    logic [7:0]  desc_len_o;
    logic [2:0]  desc_size_o;
    logic [1:0]  desc_burst_o;
    logic        desc_first_o, desc_last_o, desc_rw_o;

    axi_llc_burst_splitter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ax_valid_i(ax_valid_i), .ax_ready_o(ax_ready_o), .ax_id_i(ax_id_i),
        .ax_addr_i(ax_addr_i), .ax_len_i(ax_len_i), .ax_size_i(ax_size_i),
        .ax_burst_i(ax_burst_i),
        .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i), .desc_id_o(desc_id_o),
        .desc_addr_o(desc_addr_o), .desc_len_o(desc_len_o), .desc_size_o(desc_size_o),
        .desc_burst_o(desc_burst_o), .desc_first_o(desc_first_o), .desc_last_o(desc_last_o),
        .desc_rw_o(desc_rw_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic        first;
        logic        last;
        logic [5:0]  id;
        logic [2:0]  size;
    } desc_t;

    desc_t sb[$];
    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int rdy_mode = 0;
    int pidx = 0;
    logic [5:0] patv = 6'b110100;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_out();
        return 128'({desc_addr_o, desc_len_o, desc_burst_o, desc_first_o, desc_last_o,
                     desc_id_o, desc_size_o, desc_rw_o});
    endfunction

    function automatic desc_t mk(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                                 input logic f, input logic la, input logic [5:0] id,
                                 input logic [2:0] s);
        desc_t d;
        d.addr = a; d.len = l; d.burst = b; d.first = f; d.last = la; d.id = id; d.size = s;
        return d;
    endfunction

    // Reference: enumerate every beat address, then group consecutive beats by line.
    task automatic model_push(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        desc_t d;
        desc_t grp[$];
        logic [63:0] bytes, cont, base, a0, b;
        int n;
        n     = int'(len) + 1;
        bytes = 64'd1 << size;
        cont  = 64'(n) * bytes;
        base  = addr & ~(cont - 64'd1);
        a0    = addr & ~(bytes - 64'd1);
        if (burst == 2'd0 || (burst == 2'd2 && cont <= 64'(LB))) begin
            sb.push_back(mk(addr, len, burst, 1'b1, 1'b1, id, size));
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i == 0) b = addr;
                else if (burst == 2'd2) b = base + ((a0 - base + 64'(i) * bytes) % cont);
                else b = a0 + 64'(i) * bytes;
                if (grp.size() == 0 || (b >> LOG_LB) != (grp[grp.size()-1].addr >> LOG_LB)) begin
                    d = mk(b, 8'd0, 2'd1, 1'b0, 1'b0, id, size);
                    grp.push_back(d);
                end else begin
                    grp[grp.size()-1].len = grp[grp.size()-1].len + 8'd1;
                end
            end
            grp[0].first = 1'b1;
            grp[grp.size()-1].last = 1'b1;
            foreach (grp[k]) sb.push_back(grp[k]);
        end
    endtask

    task automatic send(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!ax_ready_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("ax_ready_wait", 128'(ax_ready_o), 128'(1));
        @(posedge clk_i); #1;
        ax_valid_i = 1'b1; ax_id_i = id; ax_addr_i = addr; ax_len_i = len;
        ax_size_i = size; ax_burst_i = burst;
        @(posedge clk_i); #1;
        ax_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || desc_valid_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_done", 128'(sb.size() == 0 && !desc_valid_o), 128'(1));
    endtask

    // desc_ready generator
    initial begin
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0: desc_ready_i = 1'b1;
                1: desc_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!desc_valid_o) desc_ready_i = 1'b0;
                    else if (pidx < 6) begin
                        desc_ready_i = patv[pidx];
                        pidx++;
                    end else desc_ready_i = 1'b1;
                end
                default: desc_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        desc_t e;
        logic [127:0] prev_pack;
        logic prev_stall, ax_hs_prev, last_hs_prev;
        prev_stall = 0; ax_hs_prev = 0; last_hs_prev = 0; prev_pack = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                sb.delete();
                prev_stall = 0; ax_hs_prev = 0; last_hs_prev = 0;
            end else begin
                if (ax_hs_prev) chk("first_latency", 128'({desc_valid_o, desc_first_o}), 128'(2'b11));
                if (last_hs_prev) chk("idle_after_last", 128'({ax_ready_o, desc_valid_o}), 128'(2'b10));
                if (prev_stall) begin
                    chk("stall_valid", 128'(desc_valid_o), 128'(1));
                    chk("stall_stable", pack_out(), prev_pack);
                end
                if (desc_valid_o) chk("ax_ready_busy", 128'(ax_ready_o), 128'(0));
                last_hs_prev = 1'b0;
                if (desc_valid_o && desc_ready_i) begin
                    hs_count++;
                    last_hs_prev = desc_last_o;
                    if (sb.size() == 0) begin
                        chk("unexpected_desc", pack_out(), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("desc_addr", 128'(desc_addr_o), 128'(e.addr));
                        chk("desc_len", 128'(desc_len_o), 128'(e.len));
                        chk("desc_burst", 128'(desc_burst_o), 128'(e.burst));
                        chk("desc_first", 128'(desc_first_o), 128'(e.first));
                        chk("desc_last", 128'(desc_last_o), 128'(e.last));
                        chk("desc_id", 128'(desc_id_o), 128'(e.id));
                        chk("desc_size", 128'(desc_size_o), 128'(e.size));
                        chk("desc_rw", 128'(desc_rw_o), 128'(0));
                    end
                end
                prev_stall = desc_valid_o && !desc_ready_i;
                prev_pack  = pack_out();
                ax_hs_prev = ax_valid_i && ax_ready_o;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int h0, n;
        logic [7:0] wl [4];
        logic [1:0] bt;
        logic [2:0] sz;
        logic [7:0] ln;
        logic [63:0] ad;
        logic [5:0] id;
        wl[0] = 8'd1; wl[1] = 8'd3; wl[2] = 8'd7; wl[3] = 8'd15;

        rst_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        chk("rst_ax_ready", 128'(ax_ready_o), 128'(1));
        chk("rst_desc_valid", 128'(desc_valid_o), 128'(0));
        chk("rst_desc_fields", pack_out(), 128'(0));
        @(posedge clk_i); #1 rst_i = 1'b0;

        // INCR crossing two line boundaries
        rdy_mode = 0;
        sb.push_back(mk(64'h1038, 8'd0, 2'd1, 1'b1, 1'b0, 6'd5, 3'd3));
        sb.push_back(mk(64'h1040, 8'd7, 2'd1, 1'b0, 1'b0, 6'd5, 3'd3));
        sb.push_back(mk(64'h1080, 8'd6, 2'd1, 1'b0, 1'b1, 6'd5, 3'd3));
        send(6'd5, 64'h1038, 8'd15, 3'd3, 2'd1);
        drain();

        // WRAP spanning two lines, wrapping back to the container base
        sb.push_back(mk(64'h1050, 8'd5, 2'd1, 1'b1, 1'b0, 6'd9, 3'd3));
        sb.push_back(mk(64'h1000, 8'd7, 2'd1, 1'b0, 1'b0, 6'd9, 3'd3));
        sb.push_back(mk(64'h1040, 8'd1, 2'd1, 1'b0, 1'b1, 6'd9, 3'd3));
        send(6'd9, 64'h1050, 8'd15, 3'd3, 2'd2);
        drain();

        // Single-descriptor WRAP and FIXED
        sb.push_back(mk(64'h1038, 8'd3, 2'd2, 1'b1, 1'b1, 6'd1, 3'd3));
        send(6'd1, 64'h1038, 8'd3, 3'd3, 2'd2);
        model_push(6'd2, 64'h2000, 8'd15, 3'd3, 2'd0);
        send(6'd2, 64'h2000, 8'd15, 3'd3, 2'd0);
        drain();

        // Back-pressure pattern
        rdy_mode = 2; pidx = 0;
        h0 = hs_count;
        model_push(6'd5, 64'h1038, 8'd15, 3'd3, 2'd1);
        send(6'd5, 64'h1038, 8'd15, 3'd3, 2'd1);
        drain();
        chk("bp_handshakes", 128'(hs_count - h0), 128'(3));

        // Reset in the middle of a burst
        rdy_mode = 3;
        model_push(6'd5, 64'h1038, 8'd15, 3'd3, 2'd1);
        send(6'd5, 64'h1038, 8'd15, 3'd3, 2'd1);
        n = 0;
        while (!desc_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_mid_seen", 128'(desc_valid_o), 128'(1));
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_valid", 128'(desc_valid_o), 128'(0));
        chk("rst_mid_ready", 128'(ax_ready_o), 128'(1));
        rdy_mode = 0;
        model_push(6'd7, 64'h1038, 8'd15, 3'd3, 2'd1);
        send(6'd7, 64'h1038, 8'd15, 3'd3, 2'd1);
        drain();

        // Aligned single line, byte-sized crossing, address rollover
        model_push(6'd3, 64'h3000, 8'd7, 3'd3, 2'd1);
        send(6'd3, 64'h3000, 8'd7, 3'd3, 2'd1);
        sb.push_back(mk(64'h303F, 8'd0, 2'd1, 1'b1, 1'b0, 6'd4, 3'd0));
        sb.push_back(mk(64'h3040, 8'd0, 2'd1, 1'b0, 1'b1, 6'd4, 3'd0));
        send(6'd4, 64'h303F, 8'd1, 3'd0, 2'd1);
        model_push(6'd6, 64'hFFFF_FFFF_FFFF_FFF0, 8'd7, 3'd3, 2'd1);
        send(6'd6, 64'hFFFF_FFFF_FFFF_FFF0, 8'd7, 3'd3, 2'd1);
        drain();

        // Randomized bursts under random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            bt = 2'($urandom_range(0, 2));
            sz = 3'($urandom_range(0, 3));
            ln = (bt == 2'd2) ? wl[$urandom_range(0, 3)]
                              : (($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                                             : 8'($urandom_range(0, 255)));
            ad = {32'($urandom), 32'($urandom)};
            if (bt == 2'd2) ad = ad & ~((64'd1 << sz) - 64'd1);
            id = 6'($urandom);
            model_push(id, ad, ln, sz, bt);
            send(id, ad, ln, sz, bt);
        end
        drain();

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
